// File: rtl/writeback_regfile_if.sv
// Bundle of the pipeline-facing signals of the writeback register file.
// The master side drives phase, indices, and data; the slave side returns operands and writeback status.
interface writeback_regfile_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       estado;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic             regwrite;
  logic [1:0]       wbsel;
  logic [2:0]       funct3;
  logic [31:0]      aluresult2;
  logic [31:0]      reddataM;
  logic [31:0]      pc;
  logic [4:0]       dbg_sel;
  logic [31:0]      readdata1;
  logic [31:0]      readdata2;
  logic [31:0]      wbdata;
  logic             wbvalid;
  logic [CNT_W-1:0] wbcount;
  logic [31:0]      dbg_data;

  modport master (
    output estado, rs1, rs2, rd, regwrite, wbsel, funct3,
           aluresult2, reddataM, pc, dbg_sel,
    input  readdata1, readdata2, wbdata, wbvalid, wbcount, dbg_data
  );

  modport slave (
    input  estado, rs1, rs2, rd, regwrite, wbsel, funct3,
           aluresult2, reddataM, pc, dbg_sel,
    output readdata1, readdata2, wbdata, wbvalid, wbcount, dbg_data
  );
endinterface

// File: rtl/writeback_regfile.sv
// 32x32 register file for a multicycle core: operand read in decode, load
// extraction and result selection in writeback, plus a retired-write counter.
module writeback_regfile #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] SP_RESET = 32'h0000_007C
) (
  input  logic                clk,
  input  logic                reset,
  writeback_regfile_if.slave  bus
);

  typedef enum logic [2:0] {
    PH_FETCH  = 3'b000,
    PH_DECODE = 3'b001,
    PH_EXEC   = 3'b010,
    PH_MEM    = 3'b011,
    PH_WB     = 3'b100
  } phase_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_NONE = 2'b11
  } wbsel_e;

  logic [31:0]      regs_q [32];
  logic [31:0]      readdata1_q, readdata1_d;
  logic [31:0]      readdata2_q, readdata2_d;
  logic [31:0]      wbdata_q, wbdata_d;
  logic             wbvalid_q, wbvalid_d;
  logic [CNT_W-1:0] wbcount_q, wbcount_d;

  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadValue;
  logic [31:0] wbValue;
  logic        isDecode;
  logic        isWriteback;
  logic        commit;

  assign isDecode    = (bus.estado == PH_DECODE);
  assign isWriteback = (bus.estado == PH_WB);

  // Byte lane and halfword come from the low address bits of the ALU result.
  always_comb begin
    loadByte = bus.reddataM[7:0];
    case (bus.aluresult2[1:0])
      2'd0:    loadByte = bus.reddataM[7:0];
      2'd1:    loadByte = bus.reddataM[15:8];
      2'd2:    loadByte = bus.reddataM[23:16];
      default: loadByte = bus.reddataM[31:24];
    endcase
    loadHalf = bus.aluresult2[1] ? bus.reddataM[31:16] : bus.reddataM[15:0];
  end

  always_comb begin
    loadValue = bus.reddataM;
    case (bus.funct3)
      3'b000:  loadValue = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadValue = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  loadValue = {24'h0, loadByte};
      3'b101:  loadValue = {16'h0, loadHalf};
      default: loadValue = bus.reddataM;
    endcase
  end

  always_comb begin
    wbValue = '0;
    case (bus.wbsel)
      WB_ALU:  wbValue = bus.aluresult2;
      WB_LOAD: wbValue = loadValue;
      WB_PC4:  wbValue = bus.pc + 32'd4;
      default: wbValue = '0;
    endcase
  end

  // x0 is protected here by the rd check, so it never needs a write mask.
  assign commit = isWriteback && bus.regwrite && (bus.rd != 5'd0) &&
                  (bus.wbsel != WB_NONE);

  always_comb begin
    readdata1_d = readdata1_q;
    readdata2_d = readdata2_q;
    wbdata_d    = wbdata_q;
    wbvalid_d   = 1'b0;
    wbcount_d   = wbcount_q;
    if (isDecode) begin
      readdata1_d = regs_q[bus.rs1];
      readdata2_d = regs_q[bus.rs2];
    end
    if (isWriteback) begin
      wbdata_d = wbValue;
    end
    if (commit) begin
      wbvalid_d = 1'b1;
      wbcount_d = wbcount_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata1_q <= '0;
      readdata2_q <= '0;
      wbdata_q    <= '0;
      wbvalid_q   <= 1'b0;
      wbcount_q   <= '0;
    end else begin
      readdata1_q <= readdata1_d;
      readdata2_q <= readdata2_d;
      wbdata_q    <= wbdata_d;
      wbvalid_q   <= wbvalid_d;
      wbcount_q   <= wbcount_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 2) ? SP_RESET : 32'h0;
      end
    end else if (commit) begin
      regs_q[bus.rd] <= wbValue;
    end
  end

  assign bus.readdata1 = readdata1_q;
  assign bus.readdata2 = readdata2_q;
  assign bus.wbdata    = wbdata_q;
  assign bus.wbvalid   = wbvalid_q;
  assign bus.wbcount   = wbcount_q;
  assign bus.dbg_data  = (bus.dbg_sel == 5'd0) ? 32'h0 : regs_q[bus.dbg_sel];

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile: reset, ALU/load/pc+4
// writeback, suppressed writes, reset override and counter wrap (CNT_W=4 copy).
module tb_writeback_regfile;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  writeback_regfile_if #(.CNT_W(16)) mainIf ();
  writeback_regfile_if #(.CNT_W(4))  smallIf ();

  writeback_regfile #(.CNT_W(16), .SP_RESET(32'h0000_007C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mainIf.slave)
  );

  writeback_regfile #(.CNT_W(4), .SP_RESET(32'h0000_007C)) dutSmall (
    .clk   (clk),
    .reset (reset),
    .bus   (smallIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge and outputs are read there too.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    mainIf.estado     = 3'b111;
    mainIf.rs1        = 5'd0;
    mainIf.rs2        = 5'd0;
    mainIf.rd         = 5'd0;
    mainIf.regwrite   = 1'b0;
    mainIf.wbsel      = 2'b00;
    mainIf.funct3     = 3'b000;
    mainIf.aluresult2 = 32'h0;
    mainIf.reddataM   = 32'h0;
    mainIf.pc         = 32'h0;
    mainIf.dbg_sel    = 5'd0;
    smallIf.estado     = 3'b111;
    smallIf.rs1        = 5'd0;
    smallIf.rs2        = 5'd0;
    smallIf.rd         = 5'd0;
    smallIf.regwrite   = 1'b0;
    smallIf.wbsel      = 2'b00;
    smallIf.funct3     = 3'b000;
    smallIf.aluresult2 = 32'h0;
    smallIf.reddataM   = 32'h0;
    smallIf.pc         = 32'h0;
    smallIf.dbg_sel    = 5'd0;
  endtask

  task automatic test_reset();
    idleInputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    mainIf.dbg_sel = 5'd2;
    #1;
    assertCount++;
    if (mainIf.dbg_data !== 32'h0000_007C) begin
      failCount++;
      $display("[TB] FAIL reset_x2: got %h expected %h", mainIf.dbg_data, 32'h7C);
    end
    mainIf.dbg_sel = 5'd5;
    #1;
    assertCount++;
    if (mainIf.dbg_data !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL reset_x5: got %h expected %h", mainIf.dbg_data, 32'h0);
    end
    assertCount++;
    if (mainIf.wbcount !== 16'd0 || mainIf.wbvalid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_count: got count %0d valid %b expected 0 0",
               mainIf.wbcount, mainIf.wbvalid);
    end
    assertCount++;
    if (mainIf.readdata1 !== 32'h0 || mainIf.readdata2 !== 32'h0 || mainIf.wbdata !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got rd1 %h rd2 %h wb %h expected all 0",
               mainIf.readdata1, mainIf.readdata2, mainIf.wbdata);
    end
  endtask

  task automatic test_alu_write();
    mainIf.estado     = 3'b100;
    mainIf.wbsel      = 2'b00;
    mainIf.aluresult2 = 32'h1234_5678;
    mainIf.rd         = 5'd5;
    mainIf.regwrite   = 1'b1;
    cycle();
    mainIf.estado   = 3'b111;
    mainIf.regwrite = 1'b0;
    mainIf.dbg_sel  = 5'd5;
    assertCount++;
    if (mainIf.wbvalid !== 1'b1 || mainIf.wbcount !== 16'd1) begin
      failCount++;
      $display("[TB] FAIL alu_commit: got valid %b count %0d expected 1 1",
               mainIf.wbvalid, mainIf.wbcount);
    end
    #1;
    assertCount++;
    if (mainIf.dbg_data !== 32'h1234_5678 || mainIf.wbdata !== 32'h1234_5678) begin
      failCount++;
      $display("[TB] FAIL alu_value: got reg %h wbdata %h expected 12345678",
               mainIf.dbg_data, mainIf.wbdata);
    end
    cycle();
    assertCount++;
    if (mainIf.wbvalid !== 1'b0 || mainIf.wbcount !== 16'd1) begin
      failCount++;
      $display("[TB] FAIL alu_pulse_end: got valid %b count %0d expected 0 1",
               mainIf.wbvalid, mainIf.wbcount);
    end
    mainIf.estado = 3'b001;
    mainIf.rs1    = 5'd5;
    mainIf.rs2    = 5'd2;
    cycle();
    mainIf.estado = 3'b111;
    mainIf.rs1    = 5'd0;
    mainIf.rs2    = 5'd0;
    assertCount++;
    if (mainIf.readdata1 !== 32'h1234_5678 || mainIf.readdata2 !== 32'h0000_007C) begin
      failCount++;
      $display("[TB] FAIL decode_read: got %h %h expected 12345678 0000007c",
               mainIf.readdata1, mainIf.readdata2);
    end
    // Operands must hold outside decode even though rs1/rs2 changed.
    cycle();
    assertCount++;
    if (mainIf.readdata1 !== 32'h1234_5678 || mainIf.readdata2 !== 32'h0000_007C) begin
      failCount++;
      $display("[TB] FAIL decode_hold: got %h %h expected 12345678 0000007c",
               mainIf.readdata1, mainIf.readdata2);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3Tab  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  offTab [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] expTab [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                                32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      mainIf.estado     = 3'b100;
      mainIf.wbsel      = 2'b01;
      mainIf.reddataM   = 32'h80FF_7F01;
      mainIf.funct3     = f3Tab[i];
      mainIf.aluresult2 = {30'h0400_0000, offTab[i]};
      mainIf.rd         = 5'd6;
      mainIf.regwrite   = 1'b1;
      cycle();
      mainIf.estado   = 3'b111;
      mainIf.regwrite = 1'b0;
      mainIf.dbg_sel  = 5'd6;
      #1;
      assertCount++;
      if (mainIf.wbdata !== expTab[i] || mainIf.dbg_data !== expTab[i]) begin
        failCount++;
        $display("[TB] FAIL load_ext_%0d: got wbdata %h reg %h expected %h",
                 i, mainIf.wbdata, mainIf.dbg_data, expTab[i]);
      end
      cycle();
    end
    assertCount++;
    if (mainIf.wbcount !== 16'd6) begin
      failCount++;
      $display("[TB] FAIL load_count: got %0d expected 6", mainIf.wbcount);
    end
  endtask

  task automatic test_no_commit();
    mainIf.estado     = 3'b100;
    mainIf.wbsel      = 2'b00;
    mainIf.aluresult2 = 32'h0000_DEAD;
    mainIf.rd         = 5'd0;
    mainIf.regwrite   = 1'b1;
    cycle();
    mainIf.dbg_sel = 5'd0;
    #1;
    assertCount++;
    if (mainIf.wbvalid !== 1'b0 || mainIf.wbcount !== 16'd6 ||
        mainIf.wbdata !== 32'h0000_DEAD || mainIf.dbg_data !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL rd0_write: got valid %b count %0d wb %h x0 %h expected 0 6 0000dead 0",
               mainIf.wbvalid, mainIf.wbcount, mainIf.wbdata, mainIf.dbg_data);
    end
    mainIf.wbsel = 2'b11;
    mainIf.rd    = 5'd5;
    cycle();
    mainIf.dbg_sel = 5'd5;
    #1;
    assertCount++;
    if (mainIf.wbvalid !== 1'b0 || mainIf.wbcount !== 16'd6 ||
        mainIf.wbdata !== 32'h0 || mainIf.dbg_data !== 32'h1234_5678) begin
      failCount++;
      $display("[TB] FAIL wbsel11_write: got valid %b count %0d wb %h x5 %h expected 0 6 0 12345678",
               mainIf.wbvalid, mainIf.wbcount, mainIf.wbdata, mainIf.dbg_data);
    end
    // A write request in a non-writeback phase must be ignored entirely.
    mainIf.estado     = 3'b010;
    mainIf.wbsel      = 2'b00;
    mainIf.aluresult2 = 32'hCAFE_0001;
    cycle();
    mainIf.estado   = 3'b111;
    mainIf.regwrite = 1'b0;
    #1;
    assertCount++;
    if (mainIf.wbvalid !== 1'b0 || mainIf.wbcount !== 16'd6 ||
        mainIf.wbdata !== 32'h0 || mainIf.dbg_data !== 32'h1234_5678) begin
      failCount++;
      $display("[TB] FAIL exec_phase_write: got valid %b count %0d wb %h x5 %h expected 0 6 0 12345678",
               mainIf.wbvalid, mainIf.wbcount, mainIf.wbdata, mainIf.dbg_data);
    end
  endtask

  task automatic test_pc_plus4();
    mainIf.estado     = 3'b100;
    mainIf.wbsel      = 2'b00;
    mainIf.aluresult2 = 32'hAAAA_5555;
    mainIf.rd         = 5'd1;
    mainIf.regwrite   = 1'b1;
    cycle();
    mainIf.estado = 3'b111;
    cycle();
    mainIf.estado = 3'b100;
    mainIf.wbsel  = 2'b10;
    mainIf.pc     = 32'hFFFF_FFFC;
    cycle();
    mainIf.estado  = 3'b111;
    mainIf.dbg_sel = 5'd1;
    #1;
    assertCount++;
    if (mainIf.dbg_data !== 32'h0 || mainIf.wbdata !== 32'h0 ||
        mainIf.wbvalid !== 1'b1 || mainIf.wbcount !== 16'd8) begin
      failCount++;
      $display("[TB] FAIL pc4_wrap: got x1 %h wb %h valid %b count %0d expected 0 0 1 8",
               mainIf.dbg_data, mainIf.wbdata, mainIf.wbvalid, mainIf.wbcount);
    end
    cycle();
    mainIf.estado = 3'b100;
    mainIf.pc     = 32'h0000_0100;
    mainIf.rd     = 5'd3;
    cycle();
    mainIf.estado   = 3'b111;
    mainIf.regwrite = 1'b0;
    mainIf.dbg_sel  = 5'd3;
    #1;
    assertCount++;
    if (mainIf.dbg_data !== 32'h0000_0104 || mainIf.wbcount !== 16'd9) begin
      failCount++;
      $display("[TB] FAIL pc4_plain: got x3 %h count %0d expected 00000104 9",
               mainIf.dbg_data, mainIf.wbcount);
    end
    cycle();
  endtask

  task automatic test_reset_override();
    mainIf.estado     = 3'b100;
    mainIf.wbsel      = 2'b00;
    mainIf.aluresult2 = 32'h0000_0055;
    mainIf.rd         = 5'd7;
    mainIf.regwrite   = 1'b1;
    reset             = 1'b1;
    cycle();
    reset           = 1'b0;
    mainIf.estado   = 3'b111;
    mainIf.regwrite = 1'b0;
    mainIf.dbg_sel  = 5'd7;
    #1;
    assertCount++;
    if (mainIf.dbg_data !== 32'h0 || mainIf.wbcount !== 16'd0 ||
        mainIf.wbvalid !== 1'b0 || mainIf.wbdata !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL reset_override: got x7 %h count %0d valid %b wb %h expected 0 0 0 0",
               mainIf.dbg_data, mainIf.wbcount, mainIf.wbvalid, mainIf.wbdata);
    end
    mainIf.dbg_sel = 5'd5;
    #1;
    assertCount++;
    if (mainIf.dbg_data !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL reset_clears_x5: got %h expected 0", mainIf.dbg_data);
    end
    // The very next edge after reset must already commit normally.
    mainIf.estado   = 3'b100;
    mainIf.regwrite = 1'b1;
    cycle();
    mainIf.estado   = 3'b111;
    mainIf.regwrite = 1'b0;
    mainIf.dbg_sel  = 5'd7;
    #1;
    assertCount++;
    if (mainIf.dbg_data !== 32'h0000_0055 || mainIf.wbcount !== 16'd1 || mainIf.wbvalid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL post_reset_commit: got x7 %h count %0d valid %b expected 00000055 1 1",
               mainIf.dbg_data, mainIf.wbcount, mainIf.wbvalid);
    end
    cycle();
  endtask

  task automatic test_wrap();
    smallIf.wbsel    = 2'b00;
    smallIf.rd       = 5'd9;
    smallIf.dbg_sel  = 5'd9;
    for (int i = 1; i <= 16; i++) begin
      smallIf.estado     = 3'b100;
      smallIf.regwrite   = 1'b1;
      smallIf.aluresult2 = 32'h100 + i;
      cycle();
      smallIf.estado   = 3'b111;
      smallIf.regwrite = 1'b0;
      if (i == 15) begin
        assertCount++;
        if (smallIf.wbcount !== 4'd15) begin
          failCount++;
          $display("[TB] FAIL wrap_15: got %0d expected 15", smallIf.wbcount);
        end
      end
      cycle();
    end
    assertCount++;
    if (smallIf.wbcount !== 4'd0 || smallIf.dbg_data !== 32'h0000_0110) begin
      failCount++;
      $display("[TB] FAIL wrap_16: got count %0d x9 %h expected 0 00000110",
               smallIf.wbcount, smallIf.dbg_data);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b0;
    idleInputs();
    test_reset();
    test_alu_write();
    test_load_ext();
    test_no_commit();
    test_pc_plus4();
    test_reset_override();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter: CNT_W, default 16, width of the retired-write counter.
REQ-002 Parameter: SP_RESET, default 32'h0000_007C, reset value of register x2.
REQ-003 Single clock domain; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 estado  input  3  multicycle phase: 000 fetch, 001 decode, 010 execute, 011 memory, 100 writeback, others idle.
REQ-007 rs1  input  5  source register 1 index.
REQ-008 rs2  input  5  source register 2 index.
REQ-009 rd  input  5  destination register index.
REQ-010 regwrite  input  1  write enable.
REQ-011 wbsel  input  2  writeback source: 00 ALU, 01 load, 10 pc+4, 11 reserved.
REQ-012 funct3  input  3  load size/sign code.
REQ-013 aluresult2  input  32  ALU result; bits [1:0] also give the load byte offset.
REQ-014 reddataM  input  32  word read by the memory stage.
REQ-015 pc  input  32  program counter of the current instruction.
REQ-016 readdata1  output  32  registered rs1 operand.
REQ-017 readdata2  output  32  registered rs2 operand.
REQ-018 wbdata  output  32  last computed writeback value.
REQ-019 wbvalid  output  1  one-cycle pulse on a committed register write.
REQ-020 wbcount  output  CNT_W  count of committed writes.
REQ-021 dbg_sel  input  5  debug register index.
REQ-022 dbg_data  output  32  combinational view of register[dbg_sel]; returns 0 for index 0.

Function
REQ-023 Storage SHALL be 32 x 32-bit registers; x0 reads 0 always and is never written.
REQ-024 On a clk edge with estado=001: readdata1 <= reg[rs1], readdata2 <= reg[rs2]; 1-cycle latency; no other phase updates them.
REQ-025 On a clk edge with estado=100, the value SHALL be selected per wbsel: 00 aluresult2; 01 extended load; 10 pc+4 mod 2^32; 11 zero.
REQ-026 The load byte is reddataM byte [aluresult2[1:0]]; the load halfword is half [aluresult2[1]].
REQ-027 Load extension by funct3: 000 sign-extended byte; 001 sign-extended half; 010 full word; 100 zero-extended byte; 101 zero-extended half; 011/110/111 full word.
REQ-028 wbdata SHALL take the selected value on every estado=100 edge, even when no write commits.
REQ-029 A write commits only when estado=100, regwrite=1, rd!=0 and wbsel!=11; reg[rd] then takes the selected value.
REQ-030 On a commit: wbvalid=1 for exactly the following cycle, and wbcount increments by 1, wrapping from 2^CNT_W-1 to 0.
REQ-031 wbvalid SHALL be 0 in every cycle that follows a non-commit edge; back-to-back commits need estado to return to 100, so pulses are never adjacent.
REQ-032 Phases 000, 010, 011 and 101-111 SHALL leave all state unchanged (wbvalid returns to 0).
REQ-033 dbg_data SHALL reflect a committed write from the cycle after the commit edge.

Reset
REQ-034 On reset=1 at a clk edge: all registers 0 except x2=SP_RESET; readdata1, readdata2 and wbdata 0; wbvalid 0; wbcount 0.
REQ-035 Reset SHALL override any estado value, including a write pending in phase 100.
REQ-036 Reset SHALL complete in one edge; normal operation resumes on the next edge.

Verification
REQ-037 Reset, then dbg_sel=2 -> dbg_data=0x0000007C; dbg_sel=5 -> 0; wbcount=0.
REQ-038 estado=100, wbsel=00, aluresult2=0x12345678, rd=5, regwrite=1 -> reg5=0x12345678, wbvalid pulses once, wbcount=1; then estado=001, rs1=5 -> readdata1=0x12345678.
REQ-039 wbsel=01, reddataM=0x80FF7F01: funct3=000, offset 3 -> 0xFFFFFF80; funct3=100, offset 1 -> 0x0000007F; funct3=001, offset 2 -> 0xFFFF80FF; funct3=101, offset 0 -> 0x00007F01.
REQ-040 rd=0, or wbsel=11, with regwrite=1 in phase 100 -> no register change, wbvalid=0, wbcount unchanged; wbdata=0 for the wbsel=11 case.
REQ-041 wbsel=10, pc=0xFFFFFFFC, rd=1 -> reg1=0x00000000; reset asserted in the same cycle as an estado=100 commit -> no write, wbcount=0.
REQ-042 CNT_W=4 with 16 commits -> wbcount wraps to 0.
